// File: rtl/pht_update_ctrl_if.sv
// Commit-slot inputs and PHT write-port outputs of the PHT update controller.
// The master drives commits and flush; the slave (controller) drives the PHT port.
interface pht_update_ctrl_if #(
    parameter int PHT_ADDRESS = 9
);
    logic                   flush_req;
    logic                   rb_valid1;
    logic [PHT_ADDRESS-1:0] rb_index1;
    logic                   rb_taken1;
    logic                   rb_valid2;
    logic [PHT_ADDRESS-1:0] rb_index2;
    logic                   rb_taken2;
    logic                   rb_ready;
    logic                   pht_upd_en;
    logic [PHT_ADDRESS-1:0] pht_upd_index;
    logic                   pht_upd_taken;
    logic                   pht_init_en;
    logic [1:0]             pht_init_val;
    logic                   init_busy;
    logic                   overflow;

    modport master (
        output flush_req, rb_valid1, rb_index1, rb_taken1,
               rb_valid2, rb_index2, rb_taken2,
        input  rb_ready, pht_upd_en, pht_upd_index, pht_upd_taken,
               pht_init_en, pht_init_val, init_busy, overflow
    );

    modport slave (
        input  flush_req, rb_valid1, rb_index1, rb_taken1,
               rb_valid2, rb_index2, rb_taken2,
        output rb_ready, pht_upd_en, pht_upd_index, pht_upd_taken,
               pht_init_en, pht_init_val, init_busy, overflow
    );
endinterface

// File: rtl/pht_update_ctrl.sv
// PHT trainer: init sweep after reset/flush, then queues two commits/cycle and issues one update/cycle.
// Latency 1 cycle into an empty queue (bypass); rb_ready drops when fewer than 2 entries would be free.
module pht_update_ctrl #(
    parameter int         PHT_ADDRESS = 9,
    parameter int         DEPTH       = 4,
    parameter logic [1:0] INIT_STATE  = 2'b01
) (
    input logic              CLK,
    input logic              reset,
    pht_update_ctrl_if.slave ifc
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = PHT_ADDRESS + 1;
    localparam logic [CW-1:0] SWEEP_END = {1'b1, {PHT_ADDRESS{1'b0}}};

    typedef enum logic {S_INIT, S_RUN} state_t;
    typedef struct packed {
        logic [PHT_ADDRESS-1:0] idx;
        logic                   taken;
    } upd_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          sweep_q;
    logic [AW-1:0]          wp_q, rp_q, wp_nx;
    logic [OW-1:0]          occ_q, free_cnt;
    upd_t                   mem [DEPTH];
    logic                   upd_en_q, init_en_q, taken_q, overflow_q;
    logic [PHT_ADDRESS-1:0] idx_q;

    logic       rdy, busy, do_init, do_pop, accept, drop, any_v, fifo_empty;
    logic [1:0] n_push;
    upd_t       ent1, ent2, slot0, head;

    assign ent1       = '{idx: ifc.rb_index1, taken: ifc.rb_taken1};
    assign ent2       = '{idx: ifc.rb_index2, taken: ifc.rb_taken2};
    assign any_v      = ifc.rb_valid1 | ifc.rb_valid2;
    assign slot0      = ifc.rb_valid1 ? ent1 : ent2;
    assign fifo_empty = (occ_q == '0);
    // An empty queue forwards the incoming first slot straight to the output register.
    assign head       = fifo_empty ? slot0 : mem[rp_q];
    assign free_cnt   = OW'(DEPTH) - occ_q + OW'(!fifo_empty);
    assign n_push     = accept ? ({1'b0, ifc.rb_valid1} + {1'b0, ifc.rb_valid2}) : 2'd0;
    assign wp_nx      = wp_q + AW'(1);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (!ifc.flush_req && sweep_q == SWEEP_END) state_d = S_RUN;
            S_RUN:   if (ifc.flush_req) state_d = S_INIT;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        rdy     = 1'b0;
        do_init = 1'b0;
        do_pop  = 1'b0;
        accept  = 1'b0;
        drop    = 1'b0;
        case (state_q)
            S_INIT: begin
                busy    = 1'b1;
                do_init = !ifc.flush_req && (sweep_q != SWEEP_END);
            end
            S_RUN: begin
                rdy    = (free_cnt >= OW'(2));
                accept = rdy && !ifc.flush_req;
                drop   = !rdy && any_v;
                do_pop = !ifc.flush_req && (!fifo_empty || (accept && any_v));
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sweep_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
        end else if (ifc.flush_req) begin
            sweep_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            occ_q   <= '0;
        end else begin
            if (do_init) sweep_q <= sweep_q + CW'(1);
            wp_q  <= wp_q + AW'(n_push);
            rp_q  <= rp_q + AW'(do_pop);
            occ_q <= occ_q + OW'(n_push) - OW'(do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (accept && any_v)                       mem[wp_q]  <= slot0;
        if (accept && ifc.rb_valid1 && ifc.rb_valid2) mem[wp_nx] <= ent2;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            init_en_q  <= 1'b0;
            upd_en_q   <= 1'b0;
            idx_q      <= '0;
            taken_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            init_en_q <= do_init;
            upd_en_q  <= do_pop;
            if (do_init) begin
                idx_q   <= sweep_q[PHT_ADDRESS-1:0];
                taken_q <= 1'b0;
            end else if (do_pop) begin
                idx_q   <= head.idx;
                taken_q <= head.taken;
            end
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign ifc.rb_ready      = rdy;
    assign ifc.init_busy     = busy;
    assign ifc.pht_init_en   = init_en_q;
    assign ifc.pht_upd_en    = upd_en_q;
    assign ifc.pht_upd_index = idx_q;
    assign ifc.pht_upd_taken = taken_q;
    assign ifc.pht_init_val  = INIT_STATE;
    assign ifc.overflow      = overflow_q;
endmodule

// File: tb/tb_pht_update_ctrl.sv
// Directed bench for pht_update_ctrl: reset, init sweeps, vector table of commits, overflow, flush and mid-sweep reset.
module tb_pht_update_ctrl;
    localparam int PA    = 9;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    pht_update_ctrl_if #(.PHT_ADDRESS(PA)) ifc();

    pht_update_ctrl #(.PHT_ADDRESS(PA), .DEPTH(DEPTH), .INIT_STATE(2'b01)) dut (
        .CLK   (CLK),
        .reset (reset),
        .ifc   (ifc)
    );

    typedef struct {
        logic          v1;
        logic [PA-1:0] i1;
        logic          t1;
        logic          v2;
        logic [PA-1:0] i2;
        logic          t2;
        logic          rdy;
        logic          en;
        logic [PA-1:0] idx;
        logic          tk;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl[22];
    logic [PA:0] got[$];
    logic [PA:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v1, input int i1, input logic t1,
                         input logic v2, input int i2, input logic t2);
        ifc.rb_valid1 = v1; ifc.rb_index1 = PA'(i1); ifc.rb_taken1 = t1;
        ifc.rb_valid2 = v2; ifc.rb_index2 = PA'(i2); ifc.rb_taken2 = t2;
    endtask

    // One cycle of commit inputs; any issued update is recorded.
    task automatic cyc(input logic v1, input int i1, input logic t1,
                       input logic v2, input int i2, input logic t2);
        drive(v1, i1, t1, v2, i2, t2);
        step();
        drive(0, 0, 0, 0, 0, 0);
        if (ifc.pht_upd_en) got.push_back({ifc.pht_upd_index, ifc.pht_upd_taken});
    endtask

    task automatic sweep(input int n, input bit finish);
        for (int k = 0; k < n; k++) begin
            step();
            chk("sweep_init_en", 32'(ifc.pht_init_en), 32'd1);
            chk("sweep_index", 32'(ifc.pht_upd_index), 32'(k));
            chk("sweep_busy", 32'(ifc.init_busy), 32'd1);
            chk("sweep_rdy", 32'(ifc.rb_ready), 32'd0);
            chk("sweep_upd_en", 32'(ifc.pht_upd_en), 32'd0);
        end
        if (finish) begin
            step();
            chk("sweep_done_busy", 32'(ifc.init_busy), 32'd0);
            chk("sweep_done_rdy", 32'(ifc.rb_ready), 32'd1);
            chk("sweep_done_init_en", 32'(ifc.pht_init_en), 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_upd_en"}, 32'(ifc.pht_upd_en), 32'd0);
        chk({tag, "_init_en"}, 32'(ifc.pht_init_en), 32'd0);
        chk({tag, "_index"}, 32'(ifc.pht_upd_index), 32'd0);
        chk({tag, "_taken"}, 32'(ifc.pht_upd_taken), 32'd0);
        chk({tag, "_rdy"}, 32'(ifc.rb_ready), 32'd0);
        chk({tag, "_busy"}, 32'(ifc.init_busy), 32'd1);
        chk({tag, "_overflow"}, 32'(ifc.overflow), 32'd0);
    endtask

    task automatic chk_got(input string name);
        chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got.size(); k++)
            chk(name, 32'(got[k]), 32'(exp_q[k]));
    endtask

    function automatic vec_t mk(input logic v1, input int i1, input logic t1,
                                input logic v2, input int i2, input logic t2,
                                input logic rdy, input logic en, input int idx, input logic tk);
        return '{v1: v1, i1: PA'(i1), t1: t1, v2: v2, i2: PA'(i2), t2: t2,
                 rdy: rdy, en: en, idx: PA'(idx), tk: tk};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Rows from an empty queue in RUN: pair latency, lone slot 2, same-index repeats, full-rate pairs.
        tbl[0]  = mk(1, 5, 1, 1, 9, 0,     1, 1, 5, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0,     1, 1, 9, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0,     1, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 33, 1,    1, 1, 33, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0,     1, 0, 0, 0);
        tbl[5]  = mk(1, 7, 1, 1, 7, 1,     1, 1, 7, 1);
        tbl[6]  = mk(1, 7, 0, 0, 0, 0,     1, 1, 7, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0,     1, 1, 7, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0,     1, 0, 0, 0);
        tbl[9]  = mk(1, 100, 1, 1, 101, 0, 1, 1, 100, 1);
        tbl[10] = mk(1, 102, 1, 1, 103, 1, 1, 1, 101, 0);
        tbl[11] = mk(1, 104, 0, 1, 105, 1, 1, 1, 102, 1);
        tbl[12] = mk(1, 106, 1, 1, 107, 0, 1, 1, 103, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0,     0, 1, 104, 0);
        tbl[14] = mk(1, 108, 1, 1, 109, 1, 1, 1, 105, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0,     0, 1, 106, 1);
        tbl[16] = mk(1, 110, 0, 1, 111, 0, 1, 1, 107, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0,     0, 1, 108, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0,     1, 1, 109, 1);
        tbl[19] = mk(0, 0, 0, 0, 0, 0,     1, 1, 110, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0,     1, 1, 111, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0,     1, 0, 0, 0);

        ifc.flush_req = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        repeat (3) step();
        chk_reset_vals("reset");
        chk("reset_init_val", 32'(ifc.pht_init_val), 32'd1);
        reset = 1'b1;
        sweep(1 << PA, 1'b1);

        for (int r = 0; r < 22; r++) begin
            drive(tbl[r].v1, 32'(tbl[r].i1), tbl[r].t1, tbl[r].v2, 32'(tbl[r].i2), tbl[r].t2);
            #1;
            chk($sformatf("row%0d_rdy", r), 32'(ifc.rb_ready), 32'(tbl[r].rdy));
            step();
            drive(0, 0, 0, 0, 0, 0);
            chk($sformatf("row%0d_en", r), 32'(ifc.pht_upd_en), 32'(tbl[r].en));
            if (tbl[r].en) begin
                chk($sformatf("row%0d_idx", r), 32'(ifc.pht_upd_index), 32'(tbl[r].idx));
                chk($sformatf("row%0d_tk", r), 32'(ifc.pht_upd_taken), 32'(tbl[r].tk));
            end
        end
        chk("table_overflow", 32'(ifc.overflow), 32'd0);

        // Fill the queue, then commit while stalled: the entry must vanish and overflow stick.
        got.delete();
        cyc(1, 200, 1, 1, 201, 1);
        cyc(1, 202, 0, 1, 203, 1);
        cyc(1, 204, 1, 1, 205, 0);
        cyc(1, 206, 0, 1, 207, 1);
        #1;
        chk("stall_rdy", 32'(ifc.rb_ready), 32'd0);
        cyc(1, 300, 1, 0, 0, 0);
        chk("overflow_set", 32'(ifc.overflow), 32'd1);
        repeat (8) cyc(0, 0, 0, 0, 0, 0);
        exp_q = '{{9'd200, 1'b1}, {9'd201, 1'b1}, {9'd202, 1'b0}, {9'd203, 1'b1},
                  {9'd204, 1'b1}, {9'd205, 1'b0}, {9'd206, 1'b0}, {9'd207, 1'b1}};
        chk_got("drop_order");
        chk("overflow_sticky", 32'(ifc.overflow), 32'd1);

        // Three entries left queued when flush arrives.
        got.delete();
        cyc(1, 10, 1, 1, 11, 1);
        cyc(1, 12, 0, 1, 13, 0);
        cyc(1, 14, 1, 1, 15, 1);
        exp_q = '{{9'd10, 1'b1}, {9'd11, 1'b1}, {9'd12, 1'b0}};
        chk_got("preflush");
        ifc.flush_req = 1'b1;
        step();
        ifc.flush_req = 1'b0;
        chk("flush_upd_en", 32'(ifc.pht_upd_en), 32'd0);
        chk("flush_busy", 32'(ifc.init_busy), 32'd1);
        chk("flush_rdy", 32'(ifc.rb_ready), 32'd0);
        sweep(1 << PA, 1'b1);

        // Flush inside INIT restarts the sweep; reset at index 200 abandons it.
        ifc.flush_req = 1'b1;
        step();
        ifc.flush_req = 1'b0;
        sweep(51, 1'b0);
        ifc.flush_req = 1'b1;
        step();
        ifc.flush_req = 1'b0;
        chk("reflush_init_en", 32'(ifc.pht_init_en), 32'd0);
        sweep(201, 1'b0);
        reset = 1'b0;
        #1;
        chk_reset_vals("midreset");
        repeat (2) step();
        reset = 1'b1;
        sweep(1 << PA, 1'b1);

        got.delete();
        cyc(1, 1, 1, 1, 2, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        exp_q = '{{9'd1, 1'b1}, {9'd2, 1'b0}};
        chk_got("post_reset_pair");
        chk("post_reset_overflow", 32'(ifc.overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pht_update_ctrl.md
PHT_UPDATE_CTRL -- requirements
Module: pht_update_ctrl

Parameters
REQ-001 SHALL provide PHT_ADDRESS, default 9, PHT index width; sweep length 2^PHT_ADDRESS.
REQ-002 SHALL provide DEPTH, default 4, update-queue entries; power of two, >= 2.
REQ-003 SHALL provide INIT_STATE, default 2'b01, counter value written by the init sweep.

Interface
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
- CLK  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous active-low reset.
- flush_req  in  1  single-cycle pulse; request a full re-initialisation of the PHT.
- rb_valid1  in  1  commit slot 1 (older) resolved branch.
- rb_index1  in  PHT_ADDRESS  slot 1 PHT index.
- rb_taken1  in  1  slot 1 actual outcome.
- rb_valid2  in  1  commit slot 2 (younger) resolved branch.
- rb_index2  in  PHT_ADDRESS  slot 2 PHT index.
- rb_taken2  in  1  slot 2 actual outcome.
- rb_ready  out  1  both slots may commit this cycle.
- pht_upd_en  out  1  train PHT[pht_upd_index] with pht_upd_taken.
- pht_upd_index  out  PHT_ADDRESS  write index (update or init).
- pht_upd_taken  out  1  training direction.
- pht_init_en  out  1  write INIT_STATE at pht_upd_index; never high with pht_upd_en.
- init_busy  out  1  init sweep in progress.
- overflow  out  1  sticky; a valid arrived while rb_ready was 0.

Function
REQ-005 SHALL implement FSM states INIT and RUN; reset enters INIT with sweep counter 0.
REQ-006 In INIT, SHALL assert pht_init_en with pht_upd_index = sweep counter, one index per cycle, incrementing 0 to 2^PHT_ADDRESS-1.
REQ-007 SHALL enter RUN on the cycle after index 2^PHT_ADDRESS-1 is written; init_busy SHALL be high exactly while in INIT.
REQ-008 In INIT, rb_ready SHALL be 0; commit inputs SHALL be ignored.
REQ-009 In RUN, flush_req SHALL discard all queued updates, clear the sweep counter and enter INIT on the next cycle.
REQ-010 A flush_req received in INIT SHALL restart the sweep at index 0.
REQ-011 SHALL buffer updates in a DEPTH-entry FIFO with an occupancy counter of $clog2(DEPTH)+1 bits.
REQ-012 rb_ready SHALL be combinational: 1 in RUN when free entries >= 2 counting the entry popped this cycle; otherwise 0.
REQ-013 When rb_ready=1, valid slots SHALL be enqueued in order slot 1 then slot 2; a lone rb_valid2 SHALL enqueue alone.
REQ-014 A valid while rb_ready=0 in RUN SHALL be dropped and SHALL set overflow, which clears only on reset.
REQ-015 In RUN, the FIFO head SHALL be popped each cycle it is non-empty and driven registered onto pht_upd_en/index/taken the next cycle; otherwise pht_upd_en=0.
REQ-016 Latency SHALL be 1 cycle for an update entering an empty FIFO; the second of a pair SHALL follow one cycle later.
REQ-017 Enqueue and pop in the same cycle SHALL be legal at any occupancy; read/write pointers SHALL wrap modulo DEPTH.
REQ-018 Consecutive updates to the same index SHALL each be issued separately, in commit order, with no coalescing.
REQ-019 pht_init_en and pht_upd_en SHALL be registered outputs and mutually exclusive.

Reset
REQ-020 While reset=0: pht_upd_en=0, pht_init_en=0, pht_upd_index=0, pht_upd_taken=0, rb_ready=0, init_busy=1, overflow=0, FIFO empty, FSM=INIT.
REQ-021 Reset asserted mid-sweep or mid-drain SHALL abandon all work; the sweep SHALL restart from index 0 after release.

Verification
REQ-022 Release reset (PHT_ADDRESS=9) -> pht_init_en high 512 consecutive cycles, index 0..511; init_busy falls and rb_ready rises on cycle 513.
REQ-023 RUN, empty FIFO, slot1 (idx 5, taken=1) + slot2 (idx 9, taken=0) -> cycle N+1: upd_en, idx 5, taken 1; N+2: idx 9, taken 0.
REQ-024 Commit pairs every cycle with DEPTH=4 -> rb_ready toggles as occupancy reaches the limit; no update lost; output order equals commit order; overflow=0.
REQ-025 Force rb_valid1=1 while rb_ready=0 -> entry absent from output, overflow=1 until reset.
REQ-026 Three queued updates, then flush_req -> queued updates never issued; sweep restarts at index 0; rb_ready=0 for 512 cycles.
REQ-027 Reset asserted at sweep index 200 -> outputs return to reset values immediately; after release, sweep restarts at index 0.
